// File: rtl/vga_frame_timing.sv
// Raster timing generator for the VGA output path: pixel/line counters with
// registered hsync, vsync, display-enable, pixel coordinates and start pulses.
module vga_frame_timing #(
  parameter int H_DISP   = 1280,
  parameter int H_FRONT  = 48,
  parameter int H_SYNC   = 112,
  parameter int H_BACK   = 248,
  parameter int V_DISP   = 1024,
  parameter int V_FRONT  = 1,
  parameter int V_SYNC   = 3,
  parameter int V_BACK   = 38,
  parameter int SYNC_POL = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        line_start,
  output logic        frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

  // Phase boundaries follow the SYNC, BACK, DISP, FRONT order on both axes.
  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_SYNC_END = 11'(H_SYNC);
  localparam logic [10:0] H_DSTART   = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] H_DEND     = 11'(H_SYNC + H_BACK + H_DISP);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_SYNC_END = 11'(V_SYNC);
  localparam logic [10:0] V_DSTART   = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] V_DEND     = 11'(V_SYNC + V_BACK + V_DISP);
  localparam logic        POL        = (SYNC_POL != 0);

  logic [10:0] h_cnt;
  logic [10:0] v_cnt;
  logic [10:0] h_next;
  logic [10:0] v_next;
  logic        h_in_sync;
  logic        v_in_sync;
  logic        active;

  always_comb begin
    h_next    = h_cnt + 11'd1;
    v_next    = v_cnt;
    if (h_cnt == H_LAST) begin
      h_next = 11'd0;
      v_next = (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
    end
    h_in_sync = (h_cnt < H_SYNC_END);
    v_in_sync = (v_cnt < V_SYNC_END);
    active    = (h_cnt >= H_DSTART) && (h_cnt < H_DEND) &&
                (v_cnt >= V_DSTART) && (v_cnt < V_DEND);
  end

  // Outputs describe the position held before this enabled edge; start
  // pulses are cleared on disabled edges so they never stretch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt       <= 11'd0;
      v_cnt       <= 11'd0;
      hsync       <= ~POL;
      vsync       <= ~POL;
      de          <= 1'b0;
      x           <= 11'd0;
      y           <= 11'd0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      h_cnt       <= h_next;
      v_cnt       <= v_next;
      hsync       <= h_in_sync ? POL : ~POL;
      vsync       <= v_in_sync ? POL : ~POL;
      de          <= active;
      x           <= active ? (h_cnt - H_DSTART) : 11'd0;
      y           <= active ? (v_cnt - V_DSTART) : 11'd0;
      line_start  <= (h_cnt == 11'd0);
      frame_start <= (h_cnt == 11'd0) && (v_cnt == 11'd0);
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_frame_timing.sv
// Bench for vga_frame_timing: two reduced-size instances (both sync polarities)
// and one default 1280x1024 instance, checked every cycle against a position model.
module tb_vga_frame_timing;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [10:0] x;
    logic [10:0] y;
    logic        ls;
    logic        fs;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        hs [3];
  logic        vs [3];
  logic        de [3];
  logic [10:0] xo [3];
  logic [10:0] yo [3];
  logic        ls [3];
  logic        fs [3];

  int vectors;
  int miscompares;

  // Small geometry: 17 clocks per line, 9 lines per frame, 153 clocks per frame.
  vga_frame_timing #(
    .H_DISP(8), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_DISP(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .SYNC_POL(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .hsync(hs[0]), .vsync(vs[0]), .de(de[0]),
    .x(xo[0]), .y(yo[0]), .line_start(ls[0]), .frame_start(fs[0])
  );

  vga_frame_timing #(
    .H_DISP(8), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_DISP(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .SYNC_POL(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .hsync(hs[1]), .vsync(vs[1]), .de(de[1]),
    .x(xo[1]), .y(yo[1]), .line_start(ls[1]), .frame_start(fs[1])
  );

  vga_frame_timing dut_d (
    .clk(clk), .rst_n(rst_n), .en(en), .hsync(hs[2]), .vsync(vs[2]), .de(de[2]),
    .x(xo[2]), .y(yo[2]), .line_start(ls[2]), .frame_start(fs[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Outputs after k enabled edges show raster position k-1 counted from (0,0).
  function automatic exp_t model(input int k, input bit last_en,
                                 input int hsw, input int hb, input int hd, input int hf,
                                 input int vsw, input int vb, input int vd, input int vf,
                                 input bit pol);
    exp_t e;
    int   ht, vt, p, h, v;
    bit   act;
    e    = '0;
    e.hs = ~pol;
    e.vs = ~pol;
    if (k == 0) return e;
    ht   = hsw + hb + hd + hf;
    vt   = vsw + vb + vd + vf;
    p    = (k - 1) % (ht * vt);
    h    = p % ht;
    v    = p / ht;
    e.hs = (h < hsw) ? pol : ~pol;
    e.vs = (v < vsw) ? pol : ~pol;
    act  = (h >= hsw + hb) && (h < hsw + hb + hd) && (v >= vsw + vb) && (v < vsw + vb + vd);
    e.de = act;
    if (act) begin
      e.x = 11'(h - hsw - hb);
      e.y = 11'(v - vsw - vb);
    end
    e.ls = last_en && (h == 0);
    e.fs = last_en && (h == 0) && (v == 0);
    return e;
  endfunction

  int k_model;
  bit last_en;
  bit armed;

  // Every-cycle comparison of all three instances against the model.
  always @(posedge clk) begin
    if (!rst_n) begin
      k_model = 0;
      last_en = 1'b0;
      armed   = 1'b1;
    end else begin
      last_en = en;
      if (en) k_model++;
    end
    #1;
    if (armed) begin
      for (int i = 0; i < 3; i++) begin
        exp_t got, req;
        got = {hs[i], vs[i], de[i], xo[i], yo[i], ls[i], fs[i]};
        case (i)
          0:       req = model(k_model, last_en, 4, 3, 8, 2, 2, 2, 4, 1, 1'b1);
          1:       req = model(k_model, last_en, 4, 3, 8, 2, 2, 2, 4, 1, 1'b0);
          default: req = model(k_model, last_en, 112, 248, 1280, 48, 3, 38, 1024, 1, 1'b1);
        endcase
        checkOutput($sformatf("model_dut%0d_k%0d", i, k_model), {5'd0, got}, {5'd0, req});
      end
    end
  end

  task automatic applyStimulus(input int n);
    repeat (n) @(negedge clk);
  endtask

  int cyc;
  int hs_low_at;
  int ls_second;
  int fs_second;
  int de_count;
  int en_cnt;
  int last_ls;
  int gap;
  bit prev_en;

  initial begin
    vectors     = 0;
    miscompares = 0;
    armed       = 1'b0;
    k_model     = 0;
    last_en     = 1'b0;
    rst_n       = 1'b1;
    en          = 1'b0;
    #2 rst_n    = 1'b0;
    applyStimulus(3);
    checkOutput("reset_hsync_pol1", {31'd0, hs[0]}, 32'd0);
    checkOutput("reset_hsync_pol0", {31'd0, hs[1]}, 32'd1);
    checkOutput("reset_de", {31'd0, de[2]}, 32'd0);
    rst_n = 1'b1;
    en    = 1'b1;

    // Continuous run: first line of the default mode, many small frames.
    hs_low_at = -1;
    ls_second = -1;
    fs_second = -1;
    de_count  = 0;
    cyc       = 0;
    for (int i = 0; i < 1800; i++) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        checkOutput("first_edge_fs", {31'd0, fs[2]}, 32'd1);
        checkOutput("first_edge_ls", {31'd0, ls[2]}, 32'd1);
        checkOutput("first_edge_hsync", {31'd0, hs[2]}, 32'd1);
        checkOutput("first_edge_vsync", {31'd0, vs[2]}, 32'd1);
        checkOutput("first_edge_de", {31'd0, de[2]}, 32'd0);
        checkOutput("first_edge_hsync_pol0", {31'd0, hs[1]}, 32'd0);
      end
      if (cyc == 76)
        checkOutput("small_de_rise", {20'd0, de[0], xo[0]}, {20'd0, 1'b1, 11'd0});
      if (cyc == 134)
        checkOutput("small_last_pixel", {9'd0, de[0], xo[0], yo[0]}, {9'd0, 1'b1, 11'd7, 11'd3});
      if (cyc == 135)
        checkOutput("small_after_last", {9'd0, de[0], xo[0], yo[0]}, 32'd0);
      if (cyc <= 153 && de[0]) de_count++;
      if (hs_low_at < 0 && hs[2] == 1'b0) hs_low_at = cyc;
      if (ls_second < 0 && cyc > 1 && ls[2]) ls_second = cyc;
      if (fs_second < 0 && cyc > 1 && fs[0]) fs_second = cyc;
    end
    checkOutput("hsync_width", hs_low_at - 1, 112);
    checkOutput("line_period", ls_second - 1, 1688);
    checkOutput("small_frame_period", fs_second - 1, 153);
    checkOutput("small_de_per_frame", de_count, 32);

    // Alternate enable; the line period counted in enabled edges is unchanged.
    en_cnt  = 0;
    last_ls = -1;
    gap     = -1;
    prev_en = en;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (prev_en) en_cnt++;
      if (!prev_en)
        checkOutput("pulse_while_disabled", {30'd0, ls[0], fs[0]}, 32'd0);
      if (ls[0]) begin
        if (last_ls >= 0) gap = en_cnt - last_ls;
        last_ls = en_cnt;
      end
      en      = (i % 2 == 1);
      prev_en = en;
    end
    checkOutput("gated_line_period", gap, 17);

    // Mid-frame reset returns to idle values at once and restarts at (0,0).
    en = 1'b1;
    applyStimulus(60);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_hsync_pol1", {31'd0, hs[0]}, 32'd0);
    checkOutput("midreset_hsync_pol0", {31'd0, hs[1]}, 32'd1);
    checkOutput("midreset_xy", {10'd0, xo[0], yo[0]}, 32'd0);
    checkOutput("midreset_de", {31'd0, de[2]}, 32'd0);
    applyStimulus(3);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    checkOutput("restart_fs_a", {31'd0, fs[0]}, 32'd1);
    checkOutput("restart_fs_b", {31'd0, fs[1]}, 32'd1);
    checkOutput("restart_fs_d", {31'd0, fs[2]}, 32'd1);
    checkOutput("restart_vsync_pol0", {31'd0, vs[1]}, 32'd0);
    applyStimulus(300);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
